// File: rtl/consmax_pack_if.sv
// consmax_pack_if: score input stream and packed-word output stream of the ConSmax row packer
interface consmax_pack_if #(
  parameter int DATA_BIT = 8,
  parameter int PACK_NUM = 4
) ();
  logic [DATA_BIT-1:0]          idata;
  logic                         idata_valid;
  logic [DATA_BIT*PACK_NUM-1:0] odata;
  logic [PACK_NUM-1:0]          odata_mask;
  logic                         odata_last;
  logic                         odata_valid;
  logic                         odata_ready;

  modport master (
    output idata, idata_valid, odata_ready,
    input  odata, odata_mask, odata_last, odata_valid
  );

  modport slave (
    input  idata, idata_valid, odata_ready,
    output odata, odata_mask, odata_last, odata_valid
  );
endinterface

// File: rtl/consmax_pack.sv
// consmax_pack: packs ConSmax scores into PACK_NUM-lane words per row, buffered in a small word FIFO; CONSMAX_PACK_OVF_EN builds the sticky overflow flag
module consmax_pack #(
  parameter int DATA_BIT   = 8,
  parameter int PACK_NUM   = 4,
  parameter int ROW_BIT    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic [ROW_BIT-1:0] cfg_row_len,
  consmax_pack_if.slave      bus,
  output logic               overflow
);
  localparam int LW = $clog2(PACK_NUM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = DATA_BIT * PACK_NUM;
  localparam int EW = WW + PACK_NUM + 1;
  localparam logic [LW-1:0]      LAST_LANE = LW'(PACK_NUM - 1);
  localparam logic [ROW_BIT-1:0] ONE = ROW_BIT'(1);
  localparam logic [CW-1:0]      DEPTH = CW'(FIFO_DEPTH);

  logic [LW-1:0]       lane_q, lane_d;
  logic [ROW_BIT-1:0]  elem_q, elem_d, len_q, len_d, cur_len;
  logic [WW-1:0]       asm_q, asm_d, word;
  logic [PACK_NUM-1:0] mask_q, mask_d, word_mask;
  logic                acc, row_end, done, push, pop, full, empty;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [EW-1:0]       head;
  logic [AW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q;

  // Assembly: a new row latches its length on the first element, so mid-row config changes wait for the next row
  always_comb begin
    acc       = bus.idata_valid & ~clr;
    cur_len   = (elem_q == '0) ? ((cfg_row_len == '0) ? ONE : cfg_row_len) : len_q;
    row_end   = elem_q == cur_len - ONE;
    word      = asm_q;
    word[lane_q*DATA_BIT +: DATA_BIT] = bus.idata;
    word_mask = mask_q;
    word_mask[lane_q] = 1'b1;
    done      = acc & ((lane_q == LAST_LANE) | row_end);
    lane_d    = lane_q;
    elem_d    = elem_q;
    len_d     = len_q;
    asm_d     = asm_q;
    mask_d    = mask_q;
    if (clr) begin
      lane_d = '0;
      elem_d = '0;
      len_d  = '0;
      asm_d  = '0;
      mask_d = '0;
    end else if (acc) begin
      len_d  = cur_len;
      elem_d = row_end ? '0 : elem_q + ONE;
      lane_d = done ? '0 : lane_q + LW'(1);
      asm_d  = done ? '0 : word;
      mask_d = done ? '0 : word_mask;
    end
  end

  // Assembly state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q <= '0;
      elem_q <= '0;
      len_q  <= '0;
      asm_q  <= '0;
      mask_q <= '0;
    end else begin
      lane_q <= lane_d;
      elem_q <= elem_d;
      len_q  <= len_d;
      asm_q  <= asm_d;
      mask_q <= mask_d;
    end
  end

  assign empty = cnt_q == '0;
  assign full  = cnt_q == DEPTH;
  assign pop   = ~clr & ~empty & bus.odata_ready;
  assign push  = done & (~full | pop);
  assign head  = mem_q[rd_q];

  assign bus.odata_valid = ~empty;
  assign bus.odata       = empty ? '0 : head[EW-1 -: WW];
  assign bus.odata_mask  = empty ? '0 : head[PACK_NUM:1];
  assign bus.odata_last  = empty ? 1'b0 : head[0];

  // FIFO pointers and occupancy; a full FIFO with a same-cycle pop still takes the push
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: {word, mask, last}
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= {word, word_mask, row_end};
    end
  end

`ifdef CONSMAX_PACK_OVF_EN
  logic ovf_q;

  // Sticky flag for a completed word dropped on a full FIFO
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= 1'b0;
    else if (clr) ovf_q <= 1'b0;
    else if (done & full & ~pop) ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_consmax_pack.sv
// tb_consmax_pack: directed scenarios checked every cycle against a queue-based packing model plus literal word expectations
module tb_consmax_pack;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  m;
    logic        l;
  } word_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] cfg_row_len = 8'd8;
  logic       overflow;
  int         tests = 0;
  int         fails = 0;

  consmax_pack_if #(.DATA_BIT(8), .PACK_NUM(4)) bus ();

  consmax_pack dut (
    .clk(clk),
    .rstn(rstn),
    .clr(clr),
    .cfg_row_len(cfg_row_len),
    .bus(bus),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  word_t      mq[$];
  word_t      log_q[$];
  logic [7:0] pend[$];
  int         pos = 0;
  int         len = 1;
  logic       movf = 1'b0;
  bit         pp, dn;
  word_t      w, h;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bus.idata_valid = v;
    bus.idata       = d;
    bus.odata_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input int i, input logic [31:0] d, input logic [3:0] m, input logic l);
    word_t e;
    e = '{d: d, m: m, l: l};
    if (i < log_q.size()) check($sformatf("word%0d", i), 64'(log_q[i]), 64'(e));
    else check($sformatf("word%0d count", i), 64'(log_q.size()), 64'(i + 1));
  endtask

  // Model: collect elements of the current word, emit on 4 lanes or row end, drop on a full queue unless popping
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      pend.delete();
      pos  = 0;
      movf = 1'b0;
    end else if (clr) begin
      mq.delete();
      pend.delete();
      pos  = 0;
      movf = 1'b0;
    end else begin
      pp = mq.size() > 0 && bus.odata_ready;
      dn = 1'b0;
      if (bus.idata_valid) begin
        if (pos == 0) len = (cfg_row_len == 0) ? 1 : int'(cfg_row_len);
        pend.push_back(bus.idata);
        pos++;
        if (pos == len || pend.size() == 4) begin
          w = '0;
          foreach (pend[k]) begin
            w.d[k*8 +: 8] = pend[k];
            w.m[k] = 1'b1;
          end
          w.l = (pos == len);
          if (pos == len) pos = 0;
          pend.delete();
          dn = 1'b1;
        end
      end
      if (pp) void'(mq.pop_front());
      if (dn) begin
        if (mq.size() < 4) mq.push_back(w);
        else movf = 1'b1;
      end
    end
  end

  // Compare every cycle on the falling edge and log accepted words
  always @(negedge clk) begin
    h = (mq.size() > 0) ? mq[0] : '0;
    check("valid", 64'(bus.odata_valid), 64'(mq.size() > 0));
    check("odata", 64'(bus.odata), 64'(h.d));
    check("mask", 64'(bus.odata_mask), 64'(h.m));
    check("last", 64'(bus.odata_last), 64'(h.l));
`ifdef CONSMAX_PACK_OVF_EN
    check("overflow", 64'(overflow), 64'(movf));
`else
    check("overflow", 64'(overflow), 64'(0));
`endif
    if (rstn && !clr && bus.odata_valid && bus.odata_ready)
      log_q.push_back('{d: bus.odata, m: bus.odata_mask, l: bus.odata_last});
  end

  initial begin
    bus.idata_valid = 1'b0;
    bus.idata       = '0;
    bus.odata_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset valid", 64'(bus.odata_valid), 64'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;
    // Full row of 8
    cfg_row_len = 8'd8;
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1);
    repeat (3) step(1'b0, 8'h0, 1'b1);
    check("s1 count", 64'(log_q.size()), 64'(2));
    chk_log(0, 32'h04030201, 4'hF, 1'b0);
    chk_log(1, 32'h08070605, 4'hF, 1'b1);
    log_q.delete();
    // Partial word with row length 5, two rows
    cfg_row_len = 8'd5;
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b1);
    for (int i = 8'h11; i <= 8'h15; i++) step(1'b1, 8'(i), 1'b1);
    repeat (3) step(1'b0, 8'h0, 1'b1);
    chk_log(0, 32'h04030201, 4'hF, 1'b0);
    chk_log(1, 32'h00000005, 4'h1, 1'b1);
    chk_log(2, 32'h14131211, 4'hF, 1'b0);
    chk_log(3, 32'h00000015, 4'h1, 1'b1);
    log_q.delete();
    // Backpressure and overflow
    cfg_row_len = 8'd4;
    for (int i = 1; i <= 20; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h0, 1'b0);
    check("s3 full valid", 64'(bus.odata_valid), 64'(1));
`ifdef CONSMAX_PACK_OVF_EN
    check("s3 overflow", 64'(overflow), 64'(1));
`endif
    repeat (6) step(1'b0, 8'h0, 1'b1);
    check("s3 count", 64'(log_q.size()), 64'(4));
    chk_log(0, 32'h04030201, 4'hF, 1'b1);
    chk_log(1, 32'h08070605, 4'hF, 1'b1);
    chk_log(2, 32'h0C0B0A09, 4'hF, 1'b1);
    chk_log(3, 32'h100F0E0D, 4'hF, 1'b1);
    check("s3 drained", 64'(bus.odata_valid), 64'(0));
    clr = 1'b1;
    step(1'b0, 8'h0, 1'b0);
    clr = 1'b0;
    check("s3 clr ovf", 64'(overflow), 64'(0));
    log_q.delete();
    // Full FIFO with a pop in the completing cycle
    for (int i = 1; i <= 19; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'd20, 1'b1);
    step(1'b0, 8'h0, 1'b0);
    check("s4 popped", 64'(log_q.size()), 64'(1));
    check("s4 overflow", 64'(overflow), 64'(0));
    repeat (6) step(1'b0, 8'h0, 1'b1);
    check("s4 count", 64'(log_q.size()), 64'(5));
    chk_log(0, 32'h04030201, 4'hF, 1'b1);
    chk_log(4, 32'h14131211, 4'hF, 1'b1);
    log_q.delete();
    // Clear mid-row
    cfg_row_len = 8'd8;
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b1);
    clr = 1'b1;
    step(1'b1, 8'h99, 1'b1);
    clr = 1'b0;
    check("s5 clr valid", 64'(bus.odata_valid), 64'(0));
    check("s5 clr ovf", 64'(overflow), 64'(0));
    for (int i = 8'h21; i <= 8'h24; i++) step(1'b1, 8'(i), 1'b1);
    repeat (2) step(1'b0, 8'h0, 1'b1);
    check("s5 count", 64'(log_q.size()), 64'(1));
    chk_log(0, 32'h24232221, 4'hF, 1'b0);
    clr = 1'b1;
    step(1'b0, 8'h0, 1'b1);
    clr = 1'b0;
    log_q.delete();
    // Same sequence with a reset pulse
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b1);
    rstn = 1'b0;
    #1 check("s5r data", 64'(bus.odata), 64'(0));
    step(1'b1, 8'h99, 1'b1);
    check("s5r valid", 64'(bus.odata_valid), 64'(0));
    step(1'b1, 8'h98, 1'b1);
    rstn = 1'b1;
    for (int i = 8'h21; i <= 8'h24; i++) step(1'b1, 8'(i), 1'b1);
    repeat (2) step(1'b0, 8'h0, 1'b1);
    check("s5r count", 64'(log_q.size()), 64'(1));
    chk_log(0, 32'h24232221, 4'hF, 1'b0);
    clr = 1'b1;
    step(1'b0, 8'h0, 1'b1);
    clr = 1'b0;
    log_q.delete();
    // Config change mid-row
    cfg_row_len = 8'd8;
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b1);
    cfg_row_len = 8'd2;
    for (int i = 4; i <= 8; i++) step(1'b1, 8'(i), 1'b1);
    step(1'b1, 8'h31, 1'b1);
    step(1'b1, 8'h32, 1'b1);
    repeat (3) step(1'b0, 8'h0, 1'b1);
    check("s6 count", 64'(log_q.size()), 64'(3));
    chk_log(0, 32'h04030201, 4'hF, 1'b0);
    chk_log(1, 32'h08070605, 4'hF, 1'b1);
    chk_log(2, 32'h00003231, 4'h3, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
